mesh_nic: RTL and testbench

- Memory-mapped network interface controller between the four-stage processor's data-memory port and the local port of a mesh router.
- Gives the processor two one-packet channel buffers, each with a status register:
  - an output channel, processor to router;
  - an input channel, router to processor.
- Packets cross to the router with a valid/ready handshake.
- An even/odd virtual-channel polarity input gates when outbound packets may leave.

---
 rtl/mesh_nic.sv | 157 +++++++++++++++
 tb/tb_mesh_nic.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mesh_nic.sv
// Memory-mapped NIC between the processor data port and a mesh router local port.
// Optional NIC_DROP_CNT_EN adds a saturating dropped-write counter in out-status.
module mesh_nic #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            addr,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  output logic                  net_si,
  input  logic                  net_ri,
  output logic [DATA_WIDTH-1:0] net_do,
  input  logic                  net_polarity,
  input  logic                  net_so,
  output logic                  net_ro,
  input  logic [DATA_WIDTH-1:0] net_di
);

  // Packet bit 0 in MSB-first numbering is the VC bit.
  localparam int unsigned VcBit = DATA_WIDTH - 1;

  typedef enum logic [1:0] {StEmpty, StFull, StSent} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] in_buf_q, in_buf_d;
  logic [DATA_WIDTH-1:0] out_buf_q, out_buf_d;
  logic                  in_full_q, in_full_d;
  logic                  out_full_q, out_full_d;
  logic [DATA_WIDTH-1:0] d_out_q, d_out_d;
  logic                  net_si_q, net_si_d;
  logic [DATA_WIDTH-1:0] net_do_q, net_do_d;
  logic [DATA_WIDTH-1:0] out_stat;

  logic rd_en, wr_en, out_wr, send_go;

  assign rd_en   = nicEn & ~nicWrEn;
  assign wr_en   = nicEn & nicWrEn;
  assign out_wr  = wr_en && (addr == 2'b10);
  assign send_go = (state_q == StFull) && net_ri && (out_buf_q[VcBit] == net_polarity);

`ifdef NIC_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (wr_en && (addr == 2'b11)) begin
      drop_cnt_d = '0;
    end else if (out_wr && out_full_q && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  always_comb begin
    out_stat        = '0;
    out_stat[0]     = out_full_q;
    out_stat[31:16] = drop_cnt_q;
  end
`else
  always_comb begin
    out_stat    = '0;
    out_stat[0] = out_full_q;
  end
`endif

  // Send FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StEmpty;
    else        state_q <= state_d;
  end

  // Send FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (out_wr) state_d = StFull;
      StFull:  if (send_go) state_d = StSent;
      StSent:  state_d = out_wr ? StFull : StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  // Send FSM: outbound datapath
  always_comb begin
    out_buf_d  = out_buf_q;
    out_full_d = out_full_q;
    net_si_d   = 1'b0;
    net_do_d   = net_do_q;
    if (out_wr && !out_full_q) begin
      out_buf_d  = d_in;
      out_full_d = 1'b1;
    end
    if (send_go) begin
      net_si_d   = 1'b1;
      net_do_d   = out_buf_q;
      out_full_d = 1'b0;
    end
  end

  // Receive path and processor reads; arrival needs empty, read-clear needs full.
  always_comb begin
    in_buf_d  = in_buf_q;
    in_full_d = in_full_q;
    d_out_d   = d_out_q;
    if (rd_en) begin
      unique case (addr)
        2'b00: begin
          d_out_d = in_buf_q;
          if (in_full_q) in_full_d = 1'b0;
        end
        2'b01: begin
          d_out_d    = '0;
          d_out_d[0] = in_full_q;
        end
        2'b10:   d_out_d = '0;
        default: d_out_d = out_stat;
      endcase
    end
    if (net_so && !in_full_q) begin
      in_buf_d  = net_di;
      in_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_buf_q   <= '0;
      out_buf_q  <= '0;
      in_full_q  <= 1'b0;
      out_full_q <= 1'b0;
      d_out_q    <= '0;
      net_si_q   <= 1'b0;
      net_do_q   <= '0;
    end else begin
      in_buf_q   <= in_buf_d;
      out_buf_q  <= out_buf_d;
      in_full_q  <= in_full_d;
      out_full_q <= out_full_d;
      d_out_q    <= d_out_d;
      net_si_q   <= net_si_d;
      net_do_q   <= net_do_d;
    end
  end

  assign d_out  = d_out_q;
  assign net_si = net_si_q;
  assign net_do = net_do_q;
  assign net_ro = ~in_full_q;

endmodule

// File: tb/tb_mesh_nic.sv
// Scoreboard bench for mesh_nic: expected reads and sends are queued at stimulus time.
module tb_mesh_nic;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in, d_out;
  logic        nicEn, nicWrEn;
  logic        net_si, net_ri, net_polarity, net_so, net_ro;
  logic [63:0] net_do, net_di;

  int checks = 0;
  int failures = 0;
  logic [63:0] send_q[$];
  logic [63:0] rd_q[$];
  logic [63:0] drop_stat;

  always #5 clk = ~clk;

  mesh_nic #(.DATA_WIDTH(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_do       (net_do),
    .net_polarity (net_polarity),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_di       (net_di)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [63:0] exp, input string tag);
    addr    = a;
    nicEn   = 1'b1;
    nicWrEn = 1'b0;
    rd_q.push_back(exp);
    @(negedge clk);
    nicEn = 1'b0;
    check_eq(tag, d_out, rd_q.pop_front());
  endtask

  task automatic wr(input logic [1:0] a, input logic [63:0] d);
    addr    = a;
    d_in    = d;
    nicEn   = 1'b1;
    nicWrEn = 1'b1;
    @(negedge clk);
    nicEn   = 1'b0;
    nicWrEn = 1'b0;
  endtask

  // Every observed send pops the oldest expected packet.
  always @(negedge clk) begin
    if (reset && net_si) begin
      if (send_q.size() == 0) check_eq("unexpected_send", 64'(net_si), 64'h0);
      else                    check_eq("net_do", net_do, send_q.pop_front());
    end
  end

  initial begin
    reset = 1'b0; addr = 2'b00; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
    net_ri = 1'b0; net_polarity = 1'b0; net_so = 1'b0; net_di = '0;
`ifdef NIC_DROP_CNT_EN
    drop_stat = 64'h0000_0000_0001_0001;
`else
    drop_stat = 64'h1;
`endif
    #3;
    check_eq("rst_d_out", d_out, 64'h0);
    check_eq("rst_net_si", 64'(net_si), 64'h0);
    check_eq("rst_net_do", net_do, 64'h0);
    check_eq("rst_net_ro", 64'(net_ro), 64'h1);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Matching polarity send
    net_ri = 1'b1;
    send_q.push_back(64'h0000_0000_DEAD_BEEF);
    wr(2'b10, 64'h0000_0000_DEAD_BEEF);
    check_eq("send_not_yet", 64'(net_si), 64'h0);
    @(negedge clk);
    check_eq("send_pulse", 64'(net_si), 64'h1);
    @(negedge clk);
    check_eq("send_pulse_end", 64'(net_si), 64'h0);
    check_eq("net_do_hold", net_do, 64'h0000_0000_DEAD_BEEF);
    rd(2'b11, 64'h0, "ostat_after_send");

    // Polarity gating
    send_q.push_back(64'h8000_0000_0000_0001);
    wr(2'b10, 64'h8000_0000_0000_0001);
    for (int i = 0; i < 5; i++) begin
      rd(2'b11, 64'h1, "ostat_pol_wait");
      check_eq("pol_hold_si", 64'(net_si), 64'h0);
    end
    net_polarity = 1'b1;
    @(negedge clk);
    check_eq("pol_send", 64'(net_si), 64'h1);
    net_polarity = 1'b0;
    @(negedge clk);
    check_eq("pol_send_end", 64'(net_si), 64'h0);
    rd(2'b11, 64'h0, "ostat_pol_done");

    // Drop on full
    net_ri = 1'b0;
    send_q.push_back(64'h11);
    wr(2'b10, 64'h11);
    wr(2'b10, 64'h22);
    rd(2'b11, drop_stat, "ostat_drop");
    net_ri = 1'b1;
    @(negedge clk);
    check_eq("drop_send", 64'(net_si), 64'h1);
    net_ri = 1'b0;
    @(negedge clk);
    wr(2'b11, 64'h0);
    rd(2'b11, 64'h0, "ostat_cnt_clr");

    // Receive
    net_so = 1'b1; net_di = 64'hCAFE;
    @(negedge clk);
    net_so = 1'b0;
    check_eq("rx_ro_low", 64'(net_ro), 64'h0);
    rd(2'b01, 64'h1, "rx_status_full");
    rd(2'b00, 64'hCAFE, "rx_data");
    check_eq("rx_ro_high", 64'(net_ro), 64'h1);
    rd(2'b01, 64'h0, "rx_status_clr");

    // Receive back-pressure
    net_so = 1'b1; net_di = 64'h1234;
    @(negedge clk);
    net_di = 64'hBAD;
    repeat (3) @(negedge clk);
    check_eq("bp_ro_low", 64'(net_ro), 64'h0);
    net_so = 1'b0;
    rd(2'b00, 64'h1234, "bp_keep");
    rd(2'b00, 64'h1234, "rx_stale");
    rd(2'b01, 64'h0, "rx_stale_no_effect");
    rd(2'b10, 64'h0, "obuf_reads_zero");
    wr(2'b00, 64'hFFFF);
    wr(2'b01, 64'hFFFF);
    rd(2'b01, 64'h0, "rx_writes_ignored");

    // Reset mid-send
    net_so = 1'b1; net_di = 64'h77;
    @(negedge clk);
    net_so = 1'b0;
    net_ri = 1'b1;
    send_q.push_back(64'h55);
    wr(2'b10, 64'h55);
    @(negedge clk);
    check_eq("rst_pre_si", 64'(net_si), 64'h1);
    #2 reset = 1'b0;
    #1;
    check_eq("rst_async_si", 64'(net_si), 64'h0);
    check_eq("rst_async_do", net_do, 64'h0);
    check_eq("rst_async_ro", 64'(net_ro), 64'h1);
    @(negedge clk);
    reset = 1'b1;
    rd(2'b01, 64'h0, "rst_in_status");
    rd(2'b11, 64'h0, "rst_out_status");

    // Reset while a packet is held discards it
    net_ri = 1'b0;
    wr(2'b10, 64'h99);
    rd(2'b11, 64'h1, "held_status");
    #2 reset = 1'b0;
    #1;
    check_eq("rst_held_d_out", d_out, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    net_ri = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_eq("discard_no_send", 64'(net_si), 64'h0);
    end
    rd(2'b11, 64'h0, "discard_status");

    check_eq("pending_sends", 64'(send_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
